// File: rtl/uart_msg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_msg_pkg: shared UART message IDs, flag bit positions, report widths,  |
// | frame-length helpers. MEM_REPORT_TX_CHECKSUM_EN appends an XOR byte.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package uart_msg_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    localparam logic [7:0] MSG_ID_RECEIVED_WRONG_NUM = 8'h03;

    localparam int FLAG_REPLACED = 0;
    localparam int FLAG_OVERRUN  = 1;

`ifdef MEM_REPORT_TX_CHECKSUM_EN
    localparam int CHECKSUM_BYTES = 1;
`else
    localparam int CHECKSUM_BYTES = 0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    function automatic int payload_bytes(input int aw, input int dw);
        return (aw + dw + 7) / 8;
    endfunction

    // Header byte + flags byte + payload (+ optional checksum).
    function automatic int frame_len(input int aw, input int dw);
        return payload_bytes(aw, dw) + 2 + CHECKSUM_BYTES;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msg_byte_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | msg_byte_serializer: loads an N-byte vector and streams it MSB byte first  |
// | over valid/ready; done pulses with the acceptance of the last byte.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module msg_byte_serializer #(
    parameter int N = 7
) (
    input  logic           clk,
    input  logic           n_reset,
    input  logic           load,
    input  logic [8*N-1:0] load_bytes,
    input  logic           tx_ready,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    output logic           done
);

    localparam int             IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [8*N-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;

    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done    = 1'b0;
        if (load) begin
            shreg_d = load_bytes;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && tx_ready) begin
            shreg_d = shreg_q << 8;
            if (idx_q == LAST_IDX) begin
                valid_d = 1'b0;
                done    = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            shreg_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign tx_data  = shreg_q[8*N-1 -: 8];
    assign tx_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/mem_report_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_report_tx: acks memory-manager number reports and frames them as UART  |
// | messages. Optional checksum byte: MEM_REPORT_TX_CHECKSUM_EN.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_report_tx #(
    parameter int         ADDR_W = uart_msg_pkg::ADDR_W,
    parameter int         DATA_W = uart_msg_pkg::DATA_W,
    parameter logic [7:0] MSG_ID = uart_msg_pkg::MSG_ID_RECEIVED_WRONG_NUM
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic [ADDR_W+DATA_W-1:0] mem_received_num,
    input  logic                     mem_received_valid,
    input  logic                     mem_received_replaced,
    input  logic                     mem_received_overrun,
    output logic                     mem_received_ack,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy
);

    import uart_msg_pkg::*;

    localparam int NUM_W = ADDR_W + DATA_W;
    localparam int PB    = payload_bytes(ADDR_W, DATA_W);
    localparam int N     = frame_len(ADDR_W, DATA_W);

    tx_state_e state_q, state_d;
    logic      ack_q, ack_d;
    logic      overrun_pending_q, overrun_pending_d;
    logic      capture;
    logic      ser_done;

    logic [8*PB-1:0] payload;
    logic [7:0]      flags;
    logic [8*N-1:0]  frame;
`ifdef MEM_REPORT_TX_CHECKSUM_EN
    logic [8*(PB+2)-1:0] body;
    logic [7:0]          cksum;
`endif

    // Frame is assembled straight from the inputs; the serializer latches it on capture.
    always_comb begin
        payload                = '0;
        payload[NUM_W-1:0]     = mem_received_num;
        flags                  = '0;
        flags[FLAG_REPLACED]   = mem_received_replaced;
        flags[FLAG_OVERRUN]    = overrun_pending_q | mem_received_overrun;
`ifdef MEM_REPORT_TX_CHECKSUM_EN
        body  = {MSG_ID, flags, payload};
        cksum = '0;
        for (int i = 0; i < PB + 2; i++) begin
            cksum = cksum ^ body[8*i +: 8];
        end
        frame = {body, cksum};
`else
        frame = {MSG_ID, flags, payload};
`endif
    end

    always_comb begin
        state_d           = state_q;
        ack_d             = 1'b0;
        overrun_pending_d = overrun_pending_q;
        capture           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_received_valid) begin
                    capture = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A capture folds any overrun into its own flags, so pending only tracks uncaptured cycles.
        if (capture) begin
            overrun_pending_d = 1'b0;
        end else if (mem_received_overrun) begin
            overrun_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q           <= ST_IDLE;
            ack_q             <= 1'b0;
            overrun_pending_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            ack_q             <= ack_d;
            overrun_pending_q <= overrun_pending_d;
        end
    end

    msg_byte_serializer #(
        .N (N)
    ) u_serializer (
        .clk        (clk),
        .n_reset    (n_reset),
        .load       (capture),
        .load_bytes (frame),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .done       (ser_done)
    );

    assign mem_received_ack = ack_q;
    assign busy             = (state_q == ST_SEND);

endmodule
`default_nettype wire

// File: tb/tb_mem_report_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_report_tx: table-driven report vectors with a byte scoreboard, plus |
// | stall, held-valid and mid-frame reset sequences.                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_report_tx;

`ifdef MEM_REPORT_TX_CHECKSUM_EN
    localparam int N_BYTES = 8;
`else
    localparam int N_BYTES = 7;
`endif

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        rep;
        logic        ovr_cap;
        logic        ovr_during;
        logic [55:0] exp;
    } vec_t;

    logic        clk;
    logic        n_reset;
    logic [39:0] mem_received_num;
    logic        mem_received_valid;
    logic        mem_received_replaced;
    logic        mem_received_overrun;
    logic        mem_received_ack;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int ack_cnt = 0;
    int acc_cnt = 0;
    logic [7:0] exp_q[$];
    vec_t tbl[6];

    mem_report_tx dut (
        .clk                   (clk),
        .n_reset               (n_reset),
        .mem_received_num      (mem_received_num),
        .mem_received_valid    (mem_received_valid),
        .mem_received_replaced (mem_received_replaced),
        .mem_received_overrun  (mem_received_overrun),
        .mem_received_ack      (mem_received_ack),
        .tx_data               (tx_data),
        .tx_valid              (tx_valid),
        .tx_ready              (tx_ready),
        .busy                  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Byte monitor: samples 2 time units after the falling edge; a transfer happens on the next rising edge.
    always begin
        @(negedge clk);
        #2;
        if (n_reset) begin
            if (mem_received_ack) ack_cnt++;
            if (tx_valid && tx_ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %0h, expected none", tx_data);
                end else begin
                    check("frame_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic push_frame(input logic [55:0] e);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(e[55-8*i -: 8]);
            x = x ^ e[55-8*i -: 8];
        end
`ifdef MEM_REPORT_TX_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic wait_ack_cnt(input int target);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #3;
            if (ack_cnt >= target) break;
        end
        check("ack_seen", {31'h0, ack_cnt >= target}, 32'h1);
    endtask

    task automatic drive_report(input vec_t v);
        int a0;
        @(negedge clk);
        a0 = ack_cnt;
        mem_received_num      = {v.addr, v.data};
        mem_received_replaced = v.rep;
        mem_received_overrun  = v.ovr_cap;
        mem_received_valid    = 1'b1;
        push_frame(v.exp);
        wait_ack_cnt(a0 + 1);
        mem_received_valid    = 1'b0;
        mem_received_overrun  = 1'b0;
        mem_received_replaced = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #3;
            if (!busy) break;
        end
        check("frame_done_busy", {31'h0, busy}, 32'h0);
        check("frame_done_valid", {31'h0, tx_valid}, 32'h0);
        check("scoreboard_empty", exp_q.size(), 32'h0);
    endtask

    task automatic run_vec(input vec_t v);
        int a0;
        a0 = ack_cnt;
        drive_report(v);
        if (v.ovr_during) begin
            @(negedge clk);
            mem_received_overrun = 1'b1;
            @(negedge clk);
            mem_received_overrun = 1'b0;
        end
        wait_idle();
        check("ack_count", ack_cnt - a0, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   a0;
        int   base;
        vec_t v;

        n_reset               = 1'b0;
        mem_received_num      = '0;
        mem_received_valid    = 1'b0;
        mem_received_replaced = 1'b0;
        mem_received_overrun  = 1'b0;
        tx_ready              = 1'b1;

        tbl[0] = '{8'h04, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 56'h03_00_04_00_00_00_01};
        tbl[1] = '{8'h01, 32'd500,       1'b0, 1'b0, 1'b0, 56'h03_02_01_00_00_01_F4};
        tbl[2] = '{8'h02, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 56'h03_01_02_12_34_56_78};
        tbl[3] = '{8'hFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 56'h03_01_FF_FF_FF_FF_FF};
        tbl[4] = '{8'h00, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 56'h03_02_00_00_00_00_00};
        tbl[5] = '{8'h80, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 56'h03_00_80_80_00_00_00};

        repeat (3) @(negedge clk);
        #3;
        check("reset_ack", {31'h0, mem_received_ack}, 32'h0);
        check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("reset_tx_data", {24'h0, tx_data}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        n_reset = 1'b1;

        for (int k = 0; k < 6; k++) begin
            run_vec(tbl[k]);
        end

        // Stall: hold tx_ready low for 10 cycles once byte2 is on the bus.
        base = acc_cnt;
        a0   = ack_cnt;
        drive_report(tbl[0]);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_cnt - base >= 2) break;
        end
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #3;
            check("stall_tx_data", {24'h0, tx_data}, 32'h04);
            check("stall_tx_valid", {31'h0, tx_valid}, 32'h1);
            @(negedge clk);
        end
        tx_ready = 1'b1;
        wait_idle();
        check("stall_ack_count", ack_cnt - a0, 32'h1);

        // Valid held through the frame: one ack per frame, capture only after the gap cycle.
        base = acc_cnt;
        a0   = ack_cnt;
        @(negedge clk);
        mem_received_num      = {8'h02, 32'h1234_5678};
        mem_received_replaced = 1'b1;
        mem_received_valid    = 1'b1;
        push_frame(tbl[2].exp);
        push_frame(tbl[2].exp);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #3;
            if (acc_cnt - base >= N_BYTES) break;
        end
        check("hold_single_ack", ack_cnt - a0, 32'h1);
        @(negedge clk);
        #3;
        check("gap_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("gap_busy", {31'h0, busy}, 32'h0);
        wait_ack_cnt(a0 + 2);
        mem_received_valid    = 1'b0;
        mem_received_replaced = 1'b0;
        wait_idle();
        check("hold_ack_total", ack_cnt - a0, 32'h2);

        // Reset while byte3 is presented, then a held report after release.
        base = acc_cnt;
        drive_report(tbl[0]);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_cnt - base >= 3) break;
        end
        n_reset = 1'b0;
        #1;
        check("midreset_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("midreset_busy", {31'h0, busy}, 32'h0);
        check("midreset_tx_data", {24'h0, tx_data}, 32'h0);
        exp_q.delete();
        v = '{8'h09, 32'h0000_00A5, 1'b0, 1'b0, 1'b0, 56'h03_00_09_00_00_00_A5};
        mem_received_num   = {v.addr, v.data};
        mem_received_valid = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        check("inreset_ack", {31'h0, mem_received_ack}, 32'h0);
        push_frame(v.exp);
        a0 = ack_cnt;
        @(negedge clk);
        n_reset = 1'b1;
        wait_ack_cnt(a0 + 1);
        mem_received_valid = 1'b0;
        wait_idle();
        check("postreset_ack_count", ack_cnt - a0, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_report_tx.md
Name: mem_report_tx

Overview:
- Consumer end of the memory manager's received-number report interface (mem_received_*).
- Accepts one report at a time and acks it. Frames the report as a UART message (header, flags, payload bytes) and streams the bytes to the UART transmitter over a valid/ready byte interface.
- Sits between the memory manager and the UART TX byte path in the test harness.

Parameters:
- ADDR_W, 8, address field width of a report.
- DATA_W, 32, data field width of a report.
- MSG_ID, 8'h03, header byte identifying a received-wrong-number message.

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous, active-low reset
- mem_received_num  in  ADDR_W+DATA_W  report payload: [ADDR_W+DATA_W-1:DATA_W] is addr, [DATA_W-1:0] is data
- mem_received_valid  in  1  report present; held by the source until acked
- mem_received_replaced  in  1  report is a replacement, not an error
- mem_received_overrun  in  1  source overrun indication (level)
- mem_received_ack  out  1  one-cycle pulse: report captured
- tx_data  out  8  frame byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts a byte when tx_valid && tx_ready
- busy  out  1  frame in progress

Behaviour:
- Clocking and reset: one clock, clk. n_reset is asynchronous, active-low.
- Reset values: mem_received_ack=0, tx_valid=0, tx_data=0, busy=0, overrun_pending=0, state IDLE.
- Payload size: PB = ceil((ADDR_W+DATA_W)/8) payload bytes, zero-padded at the MSB end. Default PB=5.
- Frame layout, in order:
  - byte0 = MSG_ID
  - byte1 = {6'b0, overrun_flag, replaced}
  - bytes 2..PB+1 = payload, MSB first
  - Frame length N = PB+2 (7 by default).
- FSM states: IDLE, SEND.
  - IDLE: if mem_received_valid is high at edge k, then registered at edge k:
    - capture num and replaced;
    - overrun_flag = overrun_pending | mem_received_overrun, then clear overrun_pending;
    - mem_received_ack=1 for exactly one cycle;
    - tx_valid=1, tx_data=byte0, busy=1, byte index=0;
    - state -> SEND.
  - SEND: on tx_valid && tx_ready, advance the index and present the next byte on the next cycle.
    - tx_data and tx_valid are held stable while tx_ready=0.
    - On acceptance of the last byte: tx_valid=0, busy=0, state -> IDLE.
- mem_received_valid is ignored in SEND. The next capture happens no earlier than the cycle after the last byte is accepted, so there is at least 1 cycle with tx_valid=0 between frames.
- overrun_pending: sticky; set in any cycle where mem_received_overrun=1 and no capture occurs. It is reported in the next frame's flags.
- Never acks twice per report. Ack is asserted only on the IDLE->SEND transition.
- Reset mid-frame: frame dropped, outputs return to reset values immediately, no ack issued, no partial bytes after reset.
- Simultaneous overrun and capture: folded into the captured frame; overrun_pending stays 0.

Optional Feature:
- Macro: MEM_REPORT_TX_CHECKSUM_EN.
- Defined: an extra final byte is appended, equal to the XOR of all preceding frame bytes. N = PB+3.
- Undefined: no checksum byte; N = PB+2.

Decomposition:
- Shared package uart_msg_pkg holds:
  - message ID constants (MSG_ID_RECEIVED_WRONG_NUM = 8'h03);
  - flag bit positions (FLAG_REPLACED=0, FLAG_OVERRUN=1);
  - the ADDR/DATA width constants;
  - the frame length function.
- Sub-module msg_byte_serializer: loads a byte vector of length N, shifts bytes out MSB first over valid/ready, and raises done. mem_report_tx keeps the FSM, capture and flag logic.

Test Plan:
- Report addr=4, data=1, replaced=0, tx_ready=1 constantly -> one ack pulse, bytes 03 00 04 00 00 00 01, then tx_valid=0. With checksum: additional byte 06.
- Report addr=2, data=0x12345678, replaced=1 -> bytes 03 01 02 12 34 56 78. With checksum: additional byte 08.
- tx_ready held low 10 cycles after byte2 is presented -> tx_data=0x04 and tx_valid stay stable for the whole stall, no byte skipped or duplicated.
- mem_received_overrun pulsed during frame 1; frame 2 report addr=1, data=500 -> frame 2 bytes 03 02 01 00 00 01 F4; frame 3 flags back to 00.
- mem_received_valid held high for 3 cycles after ack and during SEND -> exactly one ack, one frame; a second report is captured only after frame end.
- n_reset asserted at byte3 -> tx_valid=0, busy=0 immediately. After release, a held-valid report produces a fresh complete frame starting at 03.
